// File: rtl/vga_frame_sync.sv
// 640x480@60 VGA timing plus Pong object renderer; all outputs registered 1 clock after counter state.
// Free-running, no backpressure: game positions are shadowed once per frame at the start of vertical blank.
module vga_frame_sync #(
  parameter int CLK_DIV = 2,
  parameter int PAD_HW  = 25,
  parameter int PAD_HH  = 33,
  parameter int BALL_W  = 12,
  parameter int BALL_H  = 17,
  parameter int H_VIS   = 640,
  parameter int H_SS    = 656,
  parameter int H_SE    = 751,
  parameter int H_TOT   = 800,
  parameter int V_VIS   = 480,
  parameter int V_SS    = 490,
  parameter int V_SE    = 491,
  parameter int V_TOT   = 525
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [9:0]  p1_x,
  input  logic [8:0]  p1_y,
  input  logic [9:0]  p2_x,
  input  logic [8:0]  p2_y,
  input  logic [9:0]  ball_x,
  input  logic [8:0]  ball_y,
  input  logic [2:0]  winner,
  output logic        screenEnd,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [11:0] rgb
);

  localparam logic signed [10:0] HW = 11'(PAD_HW);
  localparam logic signed [10:0] HH = 11'(PAD_HH);

  logic [1:0]  div_q, div_d;
  logic        tick;
  logic [9:0]  h_q, h_d, v_q, v_d;
  logic        init_q;
  logic [9:0]  p1x_q, p2x_q, bx_q;
  logic [8:0]  p1y_q, p2y_q, by_q;
  logic [2:0]  win_q;
  logic [9:0]  r_p1x, r_p2x, r_bx;
  logic [8:0]  r_p1y, r_p2y, r_by;
  logic [2:0]  r_win;
  logic        se_q, se_d, hs_q, hs_d, vs_q, vs_d, vo_q, vo_d, load;
  logic [9:0]  px_q, py_q;
  logic [11:0] rgb_q, rgb_d;
  logic        pad1, pad2, ball;
  logic [10:0] bx_end, by_end;

  // Signed 11-bit distance keeps a centre near 0 from wrapping to ~1000.
  function automatic logic pad_hit(input logic [9:0] h, input logic [9:0] v,
                                   input logic [9:0] cx, input logic [8:0] cy);
    logic signed [10:0] dx, dy;
    dx = $signed({1'b0, h}) - $signed({1'b0, cx});
    dy = $signed({1'b0, v}) - $signed({2'b00, cy});
    return (dx >= -HW) && (dx <= HW) && (dy >= -HH) && (dy <= HH);
  endfunction

  assign tick = (div_q == 2'(CLK_DIV - 1));
  assign div_d = tick ? 2'd0 : div_q + 2'd1;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (tick) begin
      if (h_q == 10'(H_TOT - 1)) begin
        h_d = '0;
        v_d = (v_q == 10'(V_TOT - 1)) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  // Until the first clock after reset the shadows are stale, so render straight from the inputs.
  always_comb begin
    r_p1x = init_q ? p1_x   : p1x_q;
    r_p1y = init_q ? p1_y   : p1y_q;
    r_p2x = init_q ? p2_x   : p2x_q;
    r_p2y = init_q ? p2_y   : p2y_q;
    r_bx  = init_q ? ball_x : bx_q;
    r_by  = init_q ? ball_y : by_q;
    r_win = init_q ? winner : win_q;
  end

  assign se_d   = (h_q == 10'd0) && (v_q == 10'(V_VIS));
  assign load   = init_q || (se_d && !se_q);
  assign bx_end = {1'b0, r_bx} + 11'(BALL_W);
  assign by_end = {2'b00, r_by} + 11'(BALL_H);
  assign pad1   = pad_hit(h_q, v_q, r_p1x, r_p1y);
  assign pad2   = pad_hit(h_q, v_q, r_p2x, r_p2y);
  assign ball   = ({1'b0, h_q} >= {1'b0, r_bx}) && ({1'b0, h_q} < bx_end) &&
                  ({1'b0, v_q} >= {2'b00, r_by}) && ({1'b0, v_q} < by_end);
  assign vo_d   = (h_q < 10'(H_VIS)) && (v_q < 10'(V_VIS));
  assign hs_d   = !((h_q >= 10'(H_SS)) && (h_q <= 10'(H_SE)));
  assign vs_d   = !((v_q >= 10'(V_SS)) && (v_q <= 10'(V_SE)));

  always_comb begin
    rgb_d = 12'h000;
    if (vo_d) begin
      if (ball)               rgb_d = 12'hFFF;
      else if (pad1)          rgb_d = 12'h0F0;
      else if (pad2)          rgb_d = 12'h0FF;
      else if (r_win == 3'd1) rgb_d = 12'h400;
      else if (r_win == 3'd2) rgb_d = 12'h004;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_q  <= '0;
      h_q    <= '0;
      v_q    <= '0;
      init_q <= 1'b1;
      p1x_q  <= '0;
      p1y_q  <= '0;
      p2x_q  <= '0;
      p2y_q  <= '0;
      bx_q   <= '0;
      by_q   <= '0;
      win_q  <= '0;
      se_q   <= 1'b0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      vo_q   <= 1'b1;
      px_q   <= '0;
      py_q   <= '0;
      rgb_q  <= '0;
    end else begin
      div_q  <= div_d;
      h_q    <= h_d;
      v_q    <= v_d;
      init_q <= 1'b0;
      if (load) begin
        p1x_q <= p1_x;
        p1y_q <= p1_y;
        p2x_q <= p2_x;
        p2y_q <= p2_y;
        bx_q  <= ball_x;
        by_q  <= ball_y;
        win_q <= winner;
      end
      se_q  <= se_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      vo_q  <= vo_d;
      px_q  <= h_q;
      py_q  <= v_q;
      rgb_q <= rgb_d;
    end
  end

  assign screenEnd = se_q;
  assign hsync     = hs_q;
  assign vsync     = vs_q;
  assign video_on  = vo_q;
  assign pix_x     = px_q;
  assign pix_y     = py_q;
  assign rgb       = rgb_q;

endmodule

// File: tb/tb_vga_frame_sync.sv
// Scoreboarded bench on a shrunk raster (140x100, visible 128x90) so several frames fit in a short run.
module tb_vga_frame_sync;

  localparam int HV = 128, HSS = 132, HSE = 135, HT = 140;
  localparam int VV = 90,  VSS = 94,  VSE = 95,  VT = 100;
  localparam int FRAME = HT * VT;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  p1_x, p2_x, ball_x;
  logic [8:0]  p1_y, p2_y, ball_y;
  logic [2:0]  winner;
  logic        se1, hs1, vs1, vo1, se2, hs2, vs2, vo2;
  logic [9:0]  px1, py1, px2, py2;
  logic [11:0] rgb1, rgb2;

  int checks = 0, errors = 0, cyc = 0, frame_tag = 0;

  typedef struct {
    int          x;
    int          y;
    logic [11:0] rgb;
    string       name;
  } exp_t;
  exp_t sb[$];

  vga_frame_sync #(.CLK_DIV(1), .H_VIS(HV), .H_SS(HSS), .H_SE(HSE), .H_TOT(HT),
                   .V_VIS(VV), .V_SS(VSS), .V_SE(VSE), .V_TOT(VT)) u_dut (
    .clock(clock), .reset(reset), .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
    .ball_x(ball_x), .ball_y(ball_y), .winner(winner), .screenEnd(se1), .hsync(hs1),
    .vsync(vs1), .video_on(vo1), .pix_x(px1), .pix_y(py1), .rgb(rgb1));

  vga_frame_sync #(.CLK_DIV(2), .H_VIS(HV), .H_SS(HSS), .H_SE(HSE), .H_TOT(HT),
                   .V_VIS(VV), .V_SS(VSS), .V_SE(VSE), .V_TOT(VT)) u_dut2 (
    .clock(clock), .reset(reset), .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
    .ball_x(ball_x), .ball_y(ball_y), .winner(winner), .screenEnd(se2), .hsync(hs2),
    .vsync(vs2), .video_on(vo2), .pix_x(px2), .pix_y(py2), .rgb(rgb2));

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int x, input int y, input logic [11:0] c);
    exp_t e;
    e.x = x; e.y = y; e.rgb = c;
    e.name = $sformatf("F%0d(%0d,%0d)", frame_tag, x, y);
    sb.push_back(e);
  endtask

  // kind: 0 screenEnd high, 1 hsync low, 2 vsync low, 3 pixel (x,y) reached
  task automatic wait_for(input int kind, input int x, input int y, input int bound, input string nm);
    int  n = 0;
    bit  hit = 0;
    while (!hit && n < bound) begin
      @(negedge clock);
      n++;
      case (kind)
        0:       hit = (se1 === 1'b1);
        1:       hit = (hs1 === 1'b0);
        2:       hit = (vs1 === 1'b0);
        default: hit = (int'(px1) == x) && (int'(py1) == y);
      endcase
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL timeout %s: no event within %0d cycles", nm, bound);
    end
  endtask

  // Scoreboard monitor: compare whenever the DUT presents the pixel at the head of the queue.
  always @(negedge clock) begin
    if (reset && sb.size() > 0 && int'(px1) == sb[0].x && int'(py1) == sb[0].y) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.name, " rgb"}, 32'(rgb1), 32'(e.rgb));
      chk({e.name, " hsync"}, 32'(hs1), 32'(!(e.x >= HSS && e.x <= HSE)));
      chk({e.name, " vsync"}, 32'(vs1), 32'(!(e.y >= VSS && e.y <= VSE)));
      chk({e.name, " video_on"}, 32'(vo1), 32'(e.x < HV && e.y < VV));
    end
  end

  int se1_n = 0, se1_w = 0, se1_last = -1, se2_w = 0, se2_last = -1;
  logic se1_p = 1'b0, se2_p = 1'b0;

  always @(negedge clock) begin
    if (!reset) begin
      se1_p = 1'b0; se1_w = 0; se1_last = -1;
      se2_p = 1'b0; se2_w = 0; se2_last = -1;
    end else begin
      if (se1) begin
        if (!se1_p) begin
          chk("se1 pix_x", 32'(px1), 32'd0);
          chk("se1 pix_y", 32'(py1), 32'(VV));
          if (se1_last >= 0) chk("se1 period", 32'(cyc - se1_last), 32'(FRAME));
          se1_last = cyc;
          se1_n++;
        end
        se1_w++;
      end else if (se1_p) begin
        chk("se1 width", 32'(se1_w), 32'd1);
        se1_w = 0;
      end
      se1_p = se1;
      if (se2) begin
        if (!se2_p) begin
          chk("se2 pix_y", 32'(py2), 32'(VV));
          if (se2_last >= 0) chk("se2 period", 32'(cyc - se2_last), 32'(2 * FRAME));
          se2_last = cyc;
        end
        se2_w++;
      end else if (se2_p) begin
        chk("se2 width", 32'(se2_w), 32'd2);
        se2_w = 0;
      end
      se2_p = se2;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    p1_x = 10'd40;  p1_y = 9'd45;
    p2_x = 10'd110; p2_y = 9'd80;
    ball_x = 10'd90; ball_y = 9'd40;
    winner = 3'd0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst pix_x", 32'(px1), 32'd0);
    chk("rst pix_y", 32'(py1), 32'd0);
    chk("rst hsync", 32'(hs1), 32'd1);
    chk("rst vsync", 32'(vs1), 32'd1);
    chk("rst video_on", 32'(vo1), 32'd1);
    chk("rst screenEnd", 32'(se1), 32'd0);
    chk("rst rgb", 32'(rgb1), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Frame 0: p1 x15..65 y12..78, p2 x85..135 y47..113, ball x90..101 y40..56
    frame_tag = 0;
    push(14, 12, 12'h000);  push(15, 12, 12'h0F0);
    push(89, 40, 12'h000);  push(90, 40, 12'hFFF);
    push(50, 45, 12'h0F0);  push(65, 45, 12'h0F0);  push(66, 45, 12'h000);
    push(90, 45, 12'hFFF);  push(101, 45, 12'hFFF); push(102, 45, 12'h000);
    push(102, 50, 12'h0FF); push(101, 56, 12'hFFF); push(95, 57, 12'h0FF);
    push(65, 78, 12'h0F0);  push(40, 79, 12'h000);  push(127, 89, 12'h0FF);
    push(133, 89, 12'h000); push(0, 94, 12'h000);
    wait_for(3, 0, 30, FRAME, "row30");
    ball_x = 10'd50;
    wait_for(0, 0, 0, FRAME + 100, "se0");

    // Frame 1: ball moved to x50..61
    frame_tag = 1;
    push(49, 45, 12'h0F0); push(50, 45, 12'hFFF); push(61, 45, 12'hFFF);
    push(62, 45, 12'h0F0); push(90, 45, 12'h000); push(5, 60, 12'h000);
    wait_for(3, 0, 50, FRAME, "row50");
    winner = 3'd2;
    wait_for(0, 0, 0, FRAME + 100, "se1");

    // Frame 2: blue background
    frame_tag = 2;
    push(70, 5, 12'h004); push(133, 5, 12'h000); push(20, 20, 12'h0F0);
    push(50, 45, 12'hFFF); push(5, 60, 12'h004);
    p1_x = 10'd10; p1_y = 9'd20; winner = 3'd1;
    wait_for(0, 0, 0, FRAME + 100, "se2");

    // Frame 3: p1 near the corner clips to x0..35 y0..53, red background
    frame_tag = 3;
    push(0, 0, 12'h0F0);  push(35, 0, 12'h0F0);  push(36, 0, 12'h400);
    push(0, 53, 12'h0F0); push(35, 53, 12'h0F0); push(36, 53, 12'h400);
    push(0, 54, 12'h400);
    wait_for(3, 10, 60, FRAME, "row60");
    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    chk("screenEnd pulses", 32'(se1_n), 32'd3);
    chk("pre-reset rgb", 32'(rgb1), 32'h400);

    reset = 1'b0;
    #1;
    chk("midrst hsync", 32'(hs1), 32'd1);
    chk("midrst vsync", 32'(vs1), 32'd1);
    chk("midrst rgb", 32'(rgb1), 32'd0);
    chk("midrst pix_y", 32'(py1), 32'd0);
    chk("midrst video_on", 32'(vo1), 32'd1);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    wait_for(1, 0, 0, 2 * HT, "hsync low");
    chk("hsync fall pix_x", 32'(px1), 32'(HSS));
    chk("hsync fall pix_y", 32'(py1), 32'd0);
    wait_for(2, 0, 0, FRAME, "vsync low");
    chk("vsync fall pix_y", 32'(py1), 32'(VSS));
    chk("vsync fall pix_x", 32'(px1), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
